// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM plus embedded ALU decoder.
// Optional build macro ILLEGAL_OP_TRAP_EN adds a TRAP state and the illegal_o port.
module multicycle_controller #(
  parameter int NOps = 5,
  localparam int NOpsWidth = $clog2(NOps)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [6:0]           op_i,
  input  logic [2:0]           funct3_i,
  input  logic                 funct7b5_i,
  input  logic                 zero_i,
  output logic                 pc_write_o,
  output logic                 adr_src_o,
  output logic                 mem_write_o,
  output logic                 ir_write_o,
  output logic [1:0]           result_src_o,
  output logic [1:0]           alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [1:0]           imm_src_o,
  output logic                 reg_write_o,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic                 illegal_o,
`endif
  output logic [NOpsWidth-1:0] alu_control_o
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_BEQ
`ifdef ILLEGAL_OP_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t     state, state_next;
  logic [1:0] alu_op;
  logic       pc_write, mem_write, ir_write, reg_write;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_FETCH;
    else         state <= state_next;
  end

  // NOTE: every output is given a default first so no path through the case infers a latch.
  always_comb begin
    state_next   = S_FETCH;
    pc_write     = 1'b0;
    adr_src_o    = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    reg_write    = 1'b0;
    alu_op       = 2'b00;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal_o    = 1'b0;
`endif
    unique case (state)
      S_FETCH: begin
        ir_write     = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        pc_write     = 1'b1;
        state_next   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (op_i)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYP:      state_next = S_EXECUTER;
          OP_ITYP:      state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_next = S_TRAP;
`else
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_next  = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_o  = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write    = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_o = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a_o = 2'b10;
        alu_op      = 2'b10;
        state_next  = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op      = 2'b10;
        state_next  = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write    = 1'b1;
        state_next  = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a_o = 2'b10;
        alu_op      = 2'b01;
        pc_write    = zero_i;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: begin
        illegal_o  = 1'b1;
        state_next = S_TRAP;
      end
`endif
      default: state_next = S_FETCH;
    endcase
  end

  // Write strobes are forced low for the whole reset window, not just after the next edge.
  assign pc_write_o  = pc_write  & rst_ni;
  assign ir_write_o  = ir_write  & rst_ni;
  assign reg_write_o = reg_write & rst_ni;
  assign mem_write_o = mem_write & rst_ni;

  always_comb begin
    case (op_i)
      OP_SW:   imm_src_o = 2'b01;
      OP_BEQ:  imm_src_o = 2'b10;
      OP_JAL:  imm_src_o = 2'b11;
      default: imm_src_o = 2'b00;
    endcase
  end

  // Subtract only for R-type with instr[30] set; I-type addi ignores that bit.
  always_comb begin
    alu_control_o = 3'b000;
    case (alu_op)
      2'b00: alu_control_o = 3'b000;
      2'b01: alu_control_o = 3'b001;
      default: begin
        case (funct3_i)
          3'b000:  alu_control_o = (funct7b5_i & op_i[5]) ? 3'b001 : 3'b000;
          3'b010:  alu_control_o = 3'b101;
          3'b110:  alu_control_o = 3'b011;
          3'b111:  alu_control_o = 3'b010;
          default: alu_control_o = 3'b000;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; control outputs are packed into one word
// {pc_write, adr_src, mem_write, ir_write, result_src, src_a, src_b, imm_src, reg_write, alu_control}.
module tb_multicycle_controller;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       funct7b5_i;
  logic       zero_i;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       illegal;
`endif

  int tests = 0;
  int fails = 0;

  logic [15:0] obs;
  assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, imm_src, reg_write, alu_control};

  multicycle_controller dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .op_i         (op_i),
    .funct3_i     (funct3_i),
    .funct7b5_i   (funct7b5_i),
    .zero_i       (zero_i),
    .pc_write_o   (pc_write),
    .adr_src_o    (adr_src),
    .mem_write_o  (mem_write),
    .ir_write_o   (ir_write),
    .result_src_o (result_src),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .imm_src_o    (imm_src),
    .reg_write_o  (reg_write),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegal_o    (illegal),
`endif
    .alu_control_o(alu_control)
  );

  always #5 clk_i = ~clk_i;

  task automatic test_reset();
    rst_ni = 1'b0; op_i = 7'b0110011; funct3_i = 3'b000; funct7b5_i = 1'b1; zero_i = 1'b0;
    #12;
    tests++;
    if (obs !== 16'b0000_10_00_10_00_0_000) begin
      $display("FAIL reset_outputs: got %b expected %b", obs, 16'b0000_10_00_10_00_0_000); fails++;
    end
`ifdef ILLEGAL_OP_TRAP_EN
    tests++;
    if (illegal !== 1'b0) begin
      $display("FAIL reset_illegal: got %b expected 0", illegal); fails++;
    end
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_rtype(input logic [2:0] f3, input logic f7, input logic [2:0] exp_alu);
    logic [15:0] exp_seq [4];
    op_i = 7'b0110011; funct3_i = f3; funct7b5_i = f7;
    exp_seq[0] = 16'b1001_10_00_10_00_0_000;
    exp_seq[1] = 16'b0000_00_01_01_00_0_000;
    exp_seq[2] = {4'b0000, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, exp_alu};
    exp_seq[3] = 16'b0000_00_00_00_00_1_000;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk_i); #1; end
      tests++;
      if (obs !== exp_seq[i]) begin
        $display("FAIL rtype f3=%b f7=%b step %0d: got %b expected %b", f3, f7, i, obs, exp_seq[i]);
        fails++;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic test_itype(input logic [2:0] f3, input logic f7, input logic [2:0] exp_alu);
    logic [15:0] exp_seq [4];
    op_i = 7'b0010011; funct3_i = f3; funct7b5_i = f7;
    exp_seq[0] = 16'b1001_10_00_10_00_0_000;
    exp_seq[1] = 16'b0000_00_01_01_00_0_000;
    exp_seq[2] = {4'b0000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, exp_alu};
    exp_seq[3] = 16'b0000_00_00_00_00_1_000;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk_i); #1; end
      tests++;
      if (obs !== exp_seq[i]) begin
        $display("FAIL itype f3=%b f7=%b step %0d: got %b expected %b", f3, f7, i, obs, exp_seq[i]);
        fails++;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic test_lw();
    logic [15:0] exp_seq [5];
    op_i = 7'b0000011; funct3_i = 3'b010; funct7b5_i = 1'b0;
    exp_seq[0] = 16'b1001_10_00_10_00_0_000;
    exp_seq[1] = 16'b0000_00_01_01_00_0_000;
    exp_seq[2] = 16'b0000_00_10_01_00_0_000;
    exp_seq[3] = 16'b0100_00_00_00_00_0_000;
    exp_seq[4] = 16'b0000_01_00_00_00_1_000;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk_i); #1; end
      tests++;
      if (obs !== exp_seq[i]) begin
        $display("FAIL lw step %0d: got %b expected %b", i, obs, exp_seq[i]); fails++;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic test_sw();
    logic [15:0] exp_seq [4];
    op_i = 7'b0100011; funct3_i = 3'b010; funct7b5_i = 1'b0;
    exp_seq[0] = 16'b1001_10_00_10_01_0_000;
    exp_seq[1] = 16'b0000_00_01_01_01_0_000;
    exp_seq[2] = 16'b0000_00_10_01_01_0_000;
    exp_seq[3] = 16'b0110_00_00_00_01_0_000;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk_i); #1; end
      tests++;
      if (obs !== exp_seq[i]) begin
        $display("FAIL sw step %0d: got %b expected %b", i, obs, exp_seq[i]); fails++;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic test_beq(input logic zero);
    logic [15:0] exp_seq [3];
    op_i = 7'b1100011; funct3_i = 3'b000; funct7b5_i = 1'b0; zero_i = zero;
    exp_seq[0] = 16'b1001_10_00_10_10_0_000;
    exp_seq[1] = 16'b0000_00_01_01_10_0_000;
    exp_seq[2] = {zero, 3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 3'b001};
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk_i); #1; end
      tests++;
      if (obs !== exp_seq[i]) begin
        $display("FAIL beq zero=%b step %0d: got %b expected %b", zero, i, obs, exp_seq[i]); fails++;
      end
    end
    // pc_write in BEQ follows zero_i combinationally within the cycle.
    zero_i = ~zero;
    #1;
    tests++;
    if (pc_write !== ~zero) begin
      $display("FAIL beq_zero_toggle: got %b expected %b", pc_write, ~zero); fails++;
    end
    zero_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_jal();
    logic [15:0] exp_seq [4];
    op_i = 7'b1101111; funct3_i = 3'b000; funct7b5_i = 1'b0;
    exp_seq[0] = 16'b1001_10_00_10_11_0_000;
    exp_seq[1] = 16'b0000_00_01_01_11_0_000;
    exp_seq[2] = 16'b1000_00_01_10_11_0_000;
    exp_seq[3] = 16'b0000_00_00_00_11_1_000;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk_i); #1; end
      tests++;
      if (obs !== exp_seq[i]) begin
        $display("FAIL jal step %0d: got %b expected %b", i, obs, exp_seq[i]); fails++;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_store();
    op_i = 7'b0100011; funct3_i = 3'b010; funct7b5_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    tests++;
    if (mem_write !== 1'b1) begin
      $display("FAIL memwrite_before_reset: got %b expected 1", mem_write); fails++;
    end
    rst_ni = 1'b0;
    #1;
    tests++;
    if (obs !== 16'b0000_10_00_10_01_0_000) begin
      $display("FAIL reset_in_memwrite: got %b expected %b", obs, 16'b0000_10_00_10_01_0_000); fails++;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i); #1;
      tests++;
      if (obs !== 16'b0000_10_00_10_01_0_000) begin
        $display("FAIL reset_hold cycle %0d: got %b expected %b", i, obs, 16'b0000_10_00_10_01_0_000);
        fails++;
      end
    end
    rst_ni = 1'b1;
    #1;
    tests++;
    if (obs !== 16'b1001_10_00_10_01_0_000) begin
      $display("FAIL fetch_after_reset: got %b expected %b", obs, 16'b1001_10_00_10_01_0_000); fails++;
    end
  endtask

  task automatic test_unsupported();
    op_i = 7'b0000000; funct3_i = 3'b000; funct7b5_i = 1'b0;
    #1;
    tests++;
    if (obs !== 16'b1001_10_00_10_00_0_000) begin
      $display("FAIL unsup_fetch: got %b expected %b", obs, 16'b1001_10_00_10_00_0_000); fails++;
    end
    @(negedge clk_i); #1;
    tests++;
    if (obs !== 16'b0000_00_01_01_00_0_000) begin
      $display("FAIL unsup_decode: got %b expected %b", obs, 16'b0000_00_01_01_00_0_000); fails++;
    end
`ifdef ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i); #1;
      tests++;
      if (obs !== 16'h0000 || illegal !== 1'b1) begin
        $display("FAIL trap_hold cycle %0d: got %b illegal=%b expected %b illegal=1",
                 i, obs, illegal, 16'h0000);
        fails++;
      end
    end
    rst_ni = 1'b0;
    #1;
    tests++;
    if (illegal !== 1'b0) begin
      $display("FAIL trap_reset_illegal: got %b expected 0", illegal); fails++;
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
`else
    @(negedge clk_i); #1;
`endif
    tests++;
    if (obs !== 16'b1001_10_00_10_00_0_000) begin
      $display("FAIL unsup_return_fetch: got %b expected %b", obs, 16'b1001_10_00_10_00_0_000); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_rtype(3'b000, 1'b1, 3'b001);
    test_rtype(3'b000, 1'b0, 3'b000);
    test_rtype(3'b010, 1'b0, 3'b101);
    test_rtype(3'b110, 1'b0, 3'b011);
    test_rtype(3'b111, 1'b1, 3'b010);
    test_rtype(3'b100, 1'b0, 3'b000);
    test_lw();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_itype(3'b010, 1'b0, 3'b101);
    test_itype(3'b000, 1'b1, 3'b000);
    test_itype(3'b111, 1'b0, 3'b010);
    test_jal();
    test_reset_mid_store();
    test_unsupported();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
